digit_counter_mod: RTL and testbench
====================================

Name: digit_counter_mod

Overview:
- Parametrised single-digit time counter for the stopwatch chain; successor to the fixed minute-units digit.
- Counts modulo MODULUS, up or down, on a tick from the previous stage. Emits a cascade carry/borrow and a registered 7-segment pattern.
- Adds capabilities the old digit lacked: synchronous load, pause, down-count, and a time-setting mode. In setting mode a button increments the digit without carry.
- Instances are cascaded: seconds-units, seconds-tens (MODULUS=6), minute digits.

Parameters:
- MODULUS, 10: count range 0..MODULUS-1; legal 2..2**WIDTH; elaboration error otherwise.
- WIDTH, 4: digit register width; legal 1..4 (decoder covers 0..15).
- SEG_ACTIVE_LOW, 0: 1 inverts all SEG bits (common-anode display).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count tick, one-cycle pulse (previous stage CARRY_OUT or timebase).
- PAUSE  in  1  level; 1 freezes counting, ticks ignored.
- DOWN  in  1  level; 0 = count up, 1 = count down.
- LOAD  in  1  one-cycle synchronous load strobe.
- LOAD_VAL  in  WIDTH  value loaded when LOAD=1.
- SET_MODE  in  1  level; 1 = time-setting mode.
- SET_INC  in  1  raw debounced button level; rising edge increments in setting mode.
- VALUE  out  WIDTH  current digit value.
- CARRY_OUT  out  1  combinational cascade tick to next stage.
- SEG  out  7  segments {a,b,c,d,e,f,g}, SEG[6]=a, registered.

Behaviour:
- Reset (RST=1 at clock edge): VALUE=0; SEG=pattern(0), which is 7'b1111110 (inverted if SEG_ACTIVE_LOW); set-button edge register cleared to 0. CARRY_OUT=0 while RST=1.
- Per-edge priority: RST > LOAD > SET_MODE > PAUSE > EN.
- LOAD: VALUE <= LOAD_VAL. If LOAD_VAL >= MODULUS, VALUE <= MODULUS-1 (clamp). No carry generated.
- Edge detect: internal register inc_q <= SET_INC every cycle, including in run mode, so entering set mode with the button held does not increment. inc_rise = SET_INC & ~inc_q.
- SET_MODE=1:
  - EN and PAUSE ignored.
  - inc_rise increments VALUE with wrap MODULUS-1 -> 0.
  - DOWN is ignored in set mode; set always increments.
  - CARRY_OUT forced 0, so setting one digit never disturbs others.
- Run mode (SET_MODE=0, PAUSE=0, EN=1):
  - Up: VALUE==MODULUS-1 -> 0, else +1.
  - Down: VALUE==0 -> MODULUS-1, else -1.
- PAUSE=1 or EN=0 in run mode: VALUE holds.
- CARRY_OUT = EN & ~PAUSE & ~SET_MODE & ~LOAD & ~RST & terminal.
  - terminal = (VALUE==MODULUS-1) when up, (VALUE==0) when down.
  - Asserts in the same cycle as the wrapping edge, so cascaded stages advance on the same edge. Zero added latency per stage.
- SEG latency: registered from the next-state value, so SEG matches VALUE in the same cycle (no lag).
  - Hex patterns for 0..F: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Simultaneous LOAD and EN: load wins, and no carry is emitted that cycle.
- DOWN changing mid-count takes effect on the next tick; no glitch on VALUE.
- RST mid-setting: digit returns to 0 and the edge register clears. A button held through reset release produces one increment if SET_MODE=1, since inc_q=0 after reset.

Decomposition:
- Shared package (stopwatch_pkg): SEG_W=7 constant, the 16-entry segment pattern constant array, and segment bit-index constants.
- Sub-module seg7_decode: combinational 4-bit -> 7-bit lookup with polarity parameter, reused by display muxing elsewhere.
- Counter, edge detect, and carry logic stay in digit_counter_mod.

Test Plan:
- Reset/up wrap: RST=1 then release, MODULUS=10, DOWN=0, EN pulsed 10 times -> VALUE 1..9 then 0. CARRY_OUT=1 only on the 10th tick. SEG=1111011 at 9, 1111110 at 0.
- Modulo-6 down with cascade: MODULUS=6, LOAD_VAL=0 loaded, DOWN=1, one EN -> VALUE=5, CARRY_OUT=1 in the tick cycle. Next tick -> 4, CARRY_OUT=0.
- Load clamp and priority: LOAD=1, LOAD_VAL=12, EN=1, VALUE=9, MODULUS=10 -> VALUE=9 (clamped), CARRY_OUT=0.
- Set mode: SET_MODE=1, EN held 1, SET_INC held high 5 cycles then low, then pulsed twice more -> exactly 3 increments, CARRY_OUT stays 0. Starting at 9 -> 0,1,2.
- Pause: VALUE=4, PAUSE=1, 20 EN pulses -> VALUE stays 4, CARRY_OUT=0. Release PAUSE, one EN -> VALUE=5.
- Polarity/reset mid-count: SEG_ACTIVE_LOW=1, VALUE=8, RST asserted one cycle -> VALUE=0 and SEG=0000001 on that edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants: segment ordering and the hex glyph table
// used by every digit and by the display mux.
package stopwatch_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high glyphs {a,b,c,d,e,f,g} for 0..F
  localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit to 7-segment lookup with selectable output polarity.
module seg7_decode
  import stopwatch_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o
);

  logic [SEG_W-1:0] pat;

  always_comb begin
    pat          = SEG_PATTERNS[digit_i];
    seg_o        = '0;
    seg_o[SEG_A] = pat[SEG_A] ^ ACTIVE_LOW;
    seg_o[SEG_B] = pat[SEG_B] ^ ACTIVE_LOW;
    seg_o[SEG_C] = pat[SEG_C] ^ ACTIVE_LOW;
    seg_o[SEG_D] = pat[SEG_D] ^ ACTIVE_LOW;
    seg_o[SEG_E] = pat[SEG_E] ^ ACTIVE_LOW;
    seg_o[SEG_F] = pat[SEG_F] ^ ACTIVE_LOW;
    seg_o[SEG_G] = pat[SEG_G] ^ ACTIVE_LOW;
  end

endmodule

// File: rtl/digit_counter_mod.sv
// One cascadable stopwatch digit: modulo up/down counter with load, pause,
// button-driven setting mode, zero-latency carry and registered 7-seg output.
module digit_counter_mod
  import stopwatch_pkg::*;
#(
  parameter int MODULUS        = 10,
  parameter int WIDTH          = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             PAUSE,
  input  logic             DOWN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             SET_MODE,
  input  logic             SET_INC,
  output logic [WIDTH-1:0] VALUE,
  output logic             CARRY_OUT,
  output logic [SEG_W-1:0] SEG
);

  if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
    $error("digit_counter_mod: WIDTH must be 1..4");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("digit_counter_mod: MODULUS must be 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [SEG_W-1:0] SEG_RESET =
    SEG_ACTIVE_LOW ? ~SEG_PATTERNS[0] : SEG_PATTERNS[0];

  logic [WIDTH-1:0] value_q, value_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [3:0]       digit_d;
  logic             inc_q;
  logic             inc_rise;
  logic             terminal;

  // inc_q tracks the button in every mode so entering set mode with it held is not a press
  assign inc_rise = SET_INC & ~inc_q;
  assign terminal = DOWN ? (value_q == '0) : (value_q == MAX_V);
  assign CARRY_OUT = EN & ~PAUSE & ~SET_MODE & ~LOAD & ~RST & terminal;

  always_comb begin
    value_d = value_q;
    if (LOAD) begin
      value_d = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
    end else if (SET_MODE) begin
      if (inc_rise) value_d = (value_q == MAX_V) ? '0 : value_q + ONE;
    end else if (!PAUSE && EN) begin
      if (DOWN) value_d = (value_q == '0) ? MAX_V : value_q - ONE;
      else      value_d = (value_q == MAX_V) ? '0 : value_q + ONE;
    end
  end

  // Decode the next-state value so SEG and VALUE update on the same edge
  assign digit_d = 4'(value_d);

  seg7_decode #(
    .ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg7_decode (
    .digit_i(digit_d),
    .seg_o  (seg_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_q <= '0;
      seg_q   <= SEG_RESET;
      inc_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      seg_q   <= seg_d;
      inc_q   <= SET_INC;
    end
  end

  assign VALUE = value_q;
  assign SEG   = seg_q;

endmodule

// File: tb/tb_digit_counter_mod.sv
// Scoreboard bench for digit_counter_mod: three instances (mod-10, mod-6, mod-10
// active-low) share stimulus; a reference model queues expected results per edge.
module tb_digit_counter_mod;

  logic       CLK = 1'b0;
  logic       RST = 1'b0, EN = 1'b0, PAUSE = 1'b0, DOWN = 1'b0, LOAD = 1'b0;
  logic [3:0] LOAD_VAL = '0;
  logic       SET_MODE = 1'b0, SET_INC = 1'b0;

  logic [3:0] val10, val6, valn;
  logic       car10, car6, carn;
  logic [6:0] seg10, seg6, segn;

  always #5 CLK = ~CLK;

  digit_counter_mod #(.MODULUS(10), .WIDTH(4), .SEG_ACTIVE_LOW(1'b0)) u_d10 (
    .CLK(CLK), .RST(RST), .EN(EN), .PAUSE(PAUSE), .DOWN(DOWN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SET_MODE(SET_MODE), .SET_INC(SET_INC),
    .VALUE(val10), .CARRY_OUT(car10), .SEG(seg10));

  digit_counter_mod #(.MODULUS(6), .WIDTH(4), .SEG_ACTIVE_LOW(1'b0)) u_d6 (
    .CLK(CLK), .RST(RST), .EN(EN), .PAUSE(PAUSE), .DOWN(DOWN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SET_MODE(SET_MODE), .SET_INC(SET_INC),
    .VALUE(val6), .CARRY_OUT(car6), .SEG(seg6));

  digit_counter_mod #(.MODULUS(10), .WIDTH(4), .SEG_ACTIVE_LOW(1'b1)) u_dn (
    .CLK(CLK), .RST(RST), .EN(EN), .PAUSE(PAUSE), .DOWN(DOWN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SET_MODE(SET_MODE), .SET_INC(SET_INC),
    .VALUE(valn), .CARRY_OUT(carn), .SEG(segn));

  localparam logic [6:0] SEGT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct {
    logic       c10, c6, cn;
    logic [3:0] v10, v6, vn;
    logic [6:0] s10, s6, sn;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] m10 = '0, m6 = '0, mn = '0;
  logic       minc = 1'b0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  function automatic logic [3:0] m_next(int m, logic [3:0] v, logic r, logic ld,
                                        logic [3:0] lv, logic sm, logic rise,
                                        logic p, logic e, logic d);
    if (r) return 4'd0;
    if (ld) return (lv >= m) ? 4'(m - 1) : lv;
    if (sm) return rise ? ((v == m - 1) ? 4'd0 : 4'(v + 1)) : v;
    if (p || !e) return v;
    if (d) return (v == 0) ? 4'(m - 1) : 4'(v - 1);
    return (v == m - 1) ? 4'd0 : 4'(v + 1);
  endfunction

  function automatic logic m_carry(int m, logic [3:0] v, logic r, logic ld,
                                   logic sm, logic p, logic e, logic d);
    return e && !p && !sm && !ld && !r && (d ? (v == 0) : (v == m - 1));
  endfunction

  // Drive one cycle of inputs and queue the model's carry (pre-edge) and state (post-edge)
  task automatic apply(input logic r, input logic e, input logic p, input logic d,
                       input logic ld, input logic [3:0] lv, input logic sm,
                       input logic si);
    exp_t x;
    logic rise;
    RST = r; EN = e; PAUSE = p; DOWN = d; LOAD = ld; LOAD_VAL = lv;
    SET_MODE = sm; SET_INC = si;
    rise  = si & ~minc;
    x.c10 = m_carry(10, m10, r, ld, sm, p, e, d);
    x.c6  = m_carry(6,  m6,  r, ld, sm, p, e, d);
    x.cn  = m_carry(10, mn,  r, ld, sm, p, e, d);
    m10   = m_next(10, m10, r, ld, lv, sm, rise, p, e, d);
    m6    = m_next(6,  m6,  r, ld, lv, sm, rise, p, e, d);
    mn    = m_next(10, mn,  r, ld, lv, sm, rise, p, e, d);
    minc  = r ? 1'b0 : si;
    x.v10 = m10; x.v6 = m6; x.vn = mn;
    x.s10 = SEGT[m10]; x.s6 = SEGT[m6]; x.sn = ~SEGT[mn];
    sbq.push_back(x);
    #1;
  endtask

  task automatic edge_wait();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    apply(1, 1, 0, 0, 0, 4'd0, 0, 0);
    x = sbq.pop_front();
    chk_cnt++; if (car10 !== x.c10) $display("FAIL reset_carry10 got %b want %b", car10, x.c10); else pass_cnt++;
    chk_cnt++; if (car6 !== x.c6) $display("FAIL reset_carry6 got %b want %b", car6, x.c6); else pass_cnt++;
    edge_wait();
    chk_cnt++; if (val10 !== x.v10) $display("FAIL reset_value10 got %0d want %0d", val10, x.v10); else pass_cnt++;
    chk_cnt++; if (val6 !== x.v6) $display("FAIL reset_value6 got %0d want %0d", val6, x.v6); else pass_cnt++;
    chk_cnt++; if (seg10 !== 7'b1111110) $display("FAIL reset_seg10 got %b want %b", seg10, 7'b1111110); else pass_cnt++;
    chk_cnt++; if (segn !== 7'b0000001) $display("FAIL reset_segn got %b want %b", segn, 7'b0000001); else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    exp_t x;
    for (int i = 1; i <= 10; i++) begin
      apply(0, 1, 0, 0, 0, 4'd0, 0, 0);
      x = sbq.pop_front();
      chk_cnt++; if (car10 !== x.c10) $display("FAIL up_carry tick%0d got %b want %b", i, car10, x.c10); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val10 !== x.v10) $display("FAIL up_value tick%0d got %0d want %0d", i, val10, x.v10); else pass_cnt++;
      chk_cnt++; if (seg10 !== x.s10) $display("FAIL up_seg tick%0d got %b want %b", i, seg10, x.s10); else pass_cnt++;
      apply(0, 0, 0, 0, 0, 4'd0, 0, 0);
      x = sbq.pop_front();
      edge_wait();
      chk_cnt++; if (val10 !== x.v10) $display("FAIL up_hold tick%0d got %0d want %0d", i, val10, x.v10); else pass_cnt++;
    end
  endtask

  task automatic test_mod6_down();
    exp_t x;
    apply(0, 0, 0, 0, 1, 4'd0, 0, 0);
    x = sbq.pop_front();
    edge_wait();
    chk_cnt++; if (val6 !== x.v6) $display("FAIL down_load6 got %0d want %0d", val6, x.v6); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 1, 0, 4'd0, 0, 0);
      x = sbq.pop_front();
      chk_cnt++; if (car6 !== x.c6) $display("FAIL down_borrow6 step%0d got %b want %b", i, car6, x.c6); else pass_cnt++;
      chk_cnt++; if (car10 !== x.c10) $display("FAIL down_borrow10 step%0d got %b want %b", i, car10, x.c10); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val6 !== x.v6) $display("FAIL down_value6 step%0d got %0d want %0d", i, val6, x.v6); else pass_cnt++;
      chk_cnt++; if (seg6 !== x.s6) $display("FAIL down_seg6 step%0d got %b want %b", i, seg6, x.s6); else pass_cnt++;
    end
  endtask

  task automatic test_load_clamp();
    exp_t x;
    logic [3:0] lvs [2];
    lvs[0] = 4'd12;
    lvs[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 0, 1, lvs[i], 0, 0);
      x = sbq.pop_front();
      chk_cnt++; if (car10 !== x.c10) $display("FAIL load_carry10 lv%0d got %b want %b", lvs[i], car10, x.c10); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val10 !== x.v10) $display("FAIL load_value10 lv%0d got %0d want %0d", lvs[i], val10, x.v10); else pass_cnt++;
      chk_cnt++; if (val6 !== x.v6) $display("FAIL load_value6 lv%0d got %0d want %0d", lvs[i], val6, x.v6); else pass_cnt++;
    end
  endtask

  task automatic test_set_mode();
    exp_t x;
    logic [9:0] pattern;
    pattern = 10'b0101011111;
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 1, 0, 4'd0, 1, pattern[i]);
      x = sbq.pop_front();
      chk_cnt++; if (car10 !== x.c10) $display("FAIL set_carry cyc%0d got %b want %b", i, car10, x.c10); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val10 !== x.v10) $display("FAIL set_value cyc%0d got %0d want %0d", i, val10, x.v10); else pass_cnt++;
    end
    chk_cnt++; if (val10 !== 4'd2) $display("FAIL set_final got %0d want %0d", val10, 4'd2); else pass_cnt++;
  endtask

  task automatic test_pause();
    exp_t x;
    apply(0, 0, 0, 0, 1, 4'd4, 0, 0);
    x = sbq.pop_front();
    edge_wait();
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 1, 0, 0, 4'd0, 0, 0);
      x = sbq.pop_front();
      chk_cnt++; if (car10 !== x.c10) $display("FAIL pause_carry cyc%0d got %b want %b", i, car10, x.c10); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val10 !== x.v10) $display("FAIL pause_value cyc%0d got %0d want %0d", i, val10, x.v10); else pass_cnt++;
    end
    apply(0, 1, 0, 0, 0, 4'd0, 0, 0);
    x = sbq.pop_front();
    edge_wait();
    chk_cnt++; if (val10 !== x.v10) $display("FAIL pause_release got %0d want %0d", val10, x.v10); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    exp_t x;
    apply(0, 0, 0, 0, 1, 4'd8, 0, 0);
    x = sbq.pop_front();
    edge_wait();
    chk_cnt++; if (segn !== x.sn) $display("FAIL lowseg_eight got %b want %b", segn, x.sn); else pass_cnt++;
    apply(1, 1, 0, 0, 0, 4'd0, 1, 1);
    x = sbq.pop_front();
    chk_cnt++; if (carn !== x.cn) $display("FAIL rstmid_carry got %b want %b", carn, x.cn); else pass_cnt++;
    edge_wait();
    chk_cnt++; if (valn !== x.vn) $display("FAIL rstmid_value got %0d want %0d", valn, x.vn); else pass_cnt++;
    chk_cnt++; if (segn !== 7'b0000001) $display("FAIL rstmid_seg got %b want %b", segn, 7'b0000001); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 0, 4'd0, 1, 1);
      x = sbq.pop_front();
      edge_wait();
      chk_cnt++; if (valn !== x.vn) $display("FAIL rst_held_btn cyc%0d got %0d want %0d", i, valn, x.vn); else pass_cnt++;
      chk_cnt++; if (segn !== x.sn) $display("FAIL rst_held_seg cyc%0d got %b want %b", i, segn, x.sn); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    apply(0, 0, 0, 0, 0, 4'd0, 0, 1);
    x = sbq.pop_front();
    edge_wait();
    apply(0, 0, 0, 0, 0, 4'd0, 1, 1);
    x = sbq.pop_front();
    edge_wait();
    chk_cnt++; if (val10 !== x.v10) $display("FAIL held_entry got %0d want %0d", val10, x.v10); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, logic'(i >= 3 && i < 6), 0, 4'd0, 0, 0);
      x = sbq.pop_front();
      chk_cnt++; if (car6 !== x.c6) $display("FAIL b2b_carry6 cyc%0d got %b want %b", i, car6, x.c6); else pass_cnt++;
      edge_wait();
      chk_cnt++; if (val6 !== x.v6) $display("FAIL b2b_value6 cyc%0d got %0d want %0d", i, val6, x.v6); else pass_cnt++;
      chk_cnt++; if (val10 !== x.v10) $display("FAIL b2b_value10 cyc%0d got %0d want %0d", i, val10, x.v10); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_mod6_down();
    test_load_clamp();
    test_set_mode();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
